// File: rtl/frame_deserializer_if.sv
// Link-side and bus-side signals of the frame deserializer.
// The master drives the serial link and the ack; the slave rebuilds the bus word.
interface frame_deserializer_if #(
  parameter int unsigned A = 5
);
  localparam int unsigned BUS_W = (2 ** A) + 5;

  logic             frame;
  logic             msg;
  logic             bus_ack;
  logic [BUS_W-1:0] bus_out;
  logic             frame_err;

  modport master (
    output frame,
    output msg,
    output bus_ack,
    input  bus_out,
    input  frame_err
  );

  modport slave (
    input  frame,
    input  msg,
    input  bus_ack,
    output bus_out,
    output frame_err
  );
endinterface

// File: rtl/frame_deserializer.sv
// Receive end of the serial framing link: rebuilds {valid, payload, length code}
// from the frame/msg stream, holds it until acked and flags bad or dropped frames.
module frame_deserializer #(
  parameter int unsigned A = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  frame_deserializer_if.slave   link
);

  localparam int unsigned PAY_W   = 2 ** A;
  localparam int unsigned BUS_W   = PAY_W + 5;
  localparam int unsigned CNT_W   = A + 2;
  localparam int unsigned CNT_SAT = PAY_W + 1;

  localparam logic [CNT_W-1:0] CNT_SAT_C = CNT_W'(CNT_SAT);

  // Holding a word is tracked by the valid bit of bus_q rather than a state,
  // so the receiver keeps accepting frames while a word waits for its ack.
  typedef enum logic [2:0] {
    WAIT_LOW,
    IDLE,
    LEAD,
    SHIFT,
    CHECK
  } state_e;

  state_e             state_q, state_d;
  logic [PAY_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [BUS_W-1:0]   bus_q,   bus_d;
  logic               err_q,   err_d;

  logic               len_legal;
  logic [3:0]         len_code;

  // Length is legal only for an exact power of two up to the payload width.
  always_comb begin
    len_legal = 1'b0;
    len_code  = 4'd0;
    for (int unsigned i = 0; i <= A; i++) begin
      if (cnt_q == CNT_W'(1 << i)) begin
        len_legal = 1'b1;
        len_code  = 4'(i);
      end
    end
  end

  // Next-state, capture and bus/error update.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    bus_d   = bus_q;
    err_d   = 1'b0;

    if (bus_q[BUS_W-1] && link.bus_ack) begin
      bus_d = '0;
    end

    unique case (state_q)
      WAIT_LOW: begin
        if (!link.frame) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (link.frame) begin
          state_d = LEAD;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      LEAD, SHIFT: begin
        if (link.frame) begin
          state_d = SHIFT;
          shift_d = {shift_q[PAY_W-2:0], link.msg};
          cnt_d   = (cnt_q == CNT_SAT_C) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (len_legal && !bus_q[BUS_W-1]) begin
          bus_d = {1'b1, shift_q, len_code};
        end else begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOW;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= WAIT_LOW;
      shift_q <= '0;
      cnt_q   <= '0;
      bus_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      bus_q   <= bus_d;
      err_q   <= err_d;
    end
  end

  assign link.bus_out   = bus_q;
  assign link.frame_err = err_q;

endmodule

// File: tb/tb_frame_deserializer.sv
// Bench for frame_deserializer: directed vector table, multi-cycle corner
// sequences and randomized frames against a length/payload reference model.
module tb_frame_deserializer;

  localparam int unsigned A     = 5;
  localparam int unsigned BUS_W = (2 ** A) + 5;

  logic clk;
  logic reset;

  frame_deserializer_if #(.A(A)) link ();

  frame_deserializer #(.A(A)) dut (
    .clk   (clk),
    .reset (reset),
    .link  (link)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               nbits;
    logic [63:0]      data;
    bit               ack;
    bit               exp_err;
    logic [BUS_W-1:0] exp_bus;
  } vec_t;

  int               checks;
  int               failures;
  logic [BUS_W-1:0] exp_held;
  vec_t             vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    link.bus_ack = 1'b1;
    tick();
    link.bus_ack = 1'b0;
    exp_held = '0;
    chk("ack_clear", 64'(link.bus_out), 64'(exp_held));
  endtask

  // Lead slot, n payload bits MSB first, then frame low; checks latency,
  // result on the check edge and that the error is a single-cycle pulse.
  task automatic run_frame(input string tag, input int n, input logic [63:0] data,
                           input bit exp_err, input logic [BUS_W-1:0] exp_bus);
    link.frame = 1'b1;
    link.msg   = 1'($urandom);
    tick();
    for (int i = n - 1; i >= 0; i--) begin
      link.msg = data[i];
      tick();
    end
    link.frame = 1'b0;
    link.msg   = 1'($urandom);
    tick();
    chk({tag, "_latency"}, 64'(link.bus_out), 64'(exp_held));
    chk({tag, "_early_err"}, 64'(link.frame_err), 64'd0);
    tick();
    chk({tag, "_bus"}, 64'(link.bus_out), 64'(exp_bus));
    chk({tag, "_err"}, 64'(link.frame_err), 64'(exp_err));
    tick();
    chk({tag, "_err_pulse"}, 64'(link.frame_err), 64'd0);
    chk({tag, "_bus_stable"}, 64'(link.bus_out), 64'(exp_bus));
    exp_held = exp_bus;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int               n;
    bit               legal;
    bit               e_err;
    logic [63:0]      data;
    logic [63:0]      mask;
    logic [BUS_W-1:0] e_bus;

    checks   = 0;
    failures = 0;
    exp_held = '0;

    vecs[0]  = '{8,  64'hA5,          1'b0, 1'b0, {1'b1, 32'h000000A5, 4'h3}};
    vecs[1]  = '{32, 64'hDEADBEEF,    1'b1, 1'b0, {1'b1, 32'hDEADBEEF, 4'h5}};
    vecs[2]  = '{1,  64'h1,           1'b1, 1'b0, {1'b1, 32'h00000001, 4'h0}};
    vecs[3]  = '{3,  64'h5,           1'b1, 1'b1, {1'b0, 32'h0, 4'h0}};
    vecs[4]  = '{40, 64'h123456789A,  1'b0, 1'b1, {1'b0, 32'h0, 4'h0}};
    vecs[5]  = '{0,  64'h0,           1'b0, 1'b1, {1'b0, 32'h0, 4'h0}};
    vecs[6]  = '{33, 64'h1FFFFFFFF,   1'b0, 1'b1, {1'b0, 32'h0, 4'h0}};
    vecs[7]  = '{4,  64'h9,           1'b0, 1'b0, {1'b1, 32'h00000009, 4'h2}};
    vecs[8]  = '{2,  64'h2,           1'b0, 1'b1, {1'b1, 32'h00000009, 4'h2}};
    vecs[9]  = '{2,  64'h2,           1'b1, 1'b0, {1'b1, 32'h00000002, 4'h1}};
    vecs[10] = '{16, 64'h1234,        1'b1, 1'b0, {1'b1, 32'h00001234, 4'h4}};

    // Reset values, then release in the middle of a frame that must be ignored.
    reset        = 1'b0;
    link.frame   = 1'b0;
    link.msg     = 1'b0;
    link.bus_ack = 1'b0;
    repeat (3) tick();
    chk("reset_bus", 64'(link.bus_out), 64'd0);
    chk("reset_err", 64'(link.frame_err), 64'd0);
    link.frame = 1'b1;
    reset      = 1'b1;
    repeat (4) begin
      link.msg = 1'($urandom);
      tick();
    end
    link.frame = 1'b0;
    repeat (3) tick();
    chk("partial_bus", 64'(link.bus_out), 64'd0);
    chk("partial_err", 64'(link.frame_err), 64'd0);

    // Directed vector table.
    foreach (vecs[k]) begin
      if (vecs[k].ack) pulse_ack();
      run_frame($sformatf("vec%0d", k), vecs[k].nbits, vecs[k].data,
                vecs[k].exp_err, vecs[k].exp_bus);
      tick();
    end

    // Word held stable while unacked, cleared on ack.
    pulse_ack();
    run_frame("hold", 32, 64'hDEADBEEF, 1'b0, {1'b1, 32'hDEADBEEF, 4'h5});
    repeat (10) begin
      tick();
      chk("hold_stable", 64'(link.bus_out), 64'(exp_held));
    end
    pulse_ack();

    // Reset pulsed at the 5th bit of a 16-bit frame with a word held.
    run_frame("pre_rst", 8, 64'h3C, 1'b0, {1'b1, 32'h0000003C, 4'h3});
    data       = 64'h1234;
    link.frame = 1'b1;
    link.msg   = 1'($urandom);
    tick();
    for (int i = 15; i >= 11; i--) begin
      link.msg = data[i];
      tick();
    end
    #1 reset = 1'b0;
    #1;
    chk("midrst_bus", 64'(link.bus_out), 64'd0);
    chk("midrst_err", 64'(link.frame_err), 64'd0);
    exp_held = '0;
    #1 reset = 1'b1;
    for (int i = 10; i >= 0; i--) begin
      link.msg = data[i];
      tick();
    end
    link.frame = 1'b0;
    repeat (4) begin
      tick();
      chk("midrst_ignored_bus", 64'(link.bus_out), 64'd0);
      chk("midrst_ignored_err", 64'(link.frame_err), 64'd0);
    end
    run_frame("post_rst", 16, 64'h1234, 1'b0, {1'b1, 32'h00001234, 4'h4});

    // Randomized frames against the reference model.
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 2) == 0) pulse_ack();
      if ($urandom_range(0, 3) < 2) n = 1 << $urandom_range(0, 5);
      else                          n = int'($urandom_range(0, 40));
      data  = {$urandom, $urandom};
      legal = (n >= 1) && (n <= 32) && ((n & (n - 1)) == 0);
      if (legal && !exp_held[BUS_W-1]) begin
        mask  = (64'd1 << n) - 64'd1;
        e_bus = {1'b1, 32'(data & mask), 4'($clog2(n))};
        e_err = 1'b0;
      end else begin
        e_bus = exp_held;
        e_err = 1'b1;
      end
      run_frame($sformatf("rnd%0d_n%0d", r, n), n, data, e_err, e_bus);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_deserializer.md
Name: frame_deserializer

Overview:
Receive end of the team's serial framing link: takes the `frame`/`msg` serial stream produced by the bus serializer and rebuilds the parallel bus word. The rebuilt word is {valid, 32-bit payload, 4-bit length code}, and the payload length is 2^code bits, sent MSB first. Sits at the decrypt-side input, so the downstream stage sees the same bus format the serializer consumed. Adds a hold/ack handshake and error flagging.

Parameters:
A, 5, log2 of max payload bits (max payload = 2**A = 32)
BUS_W, 2**A+5 (37), bus word width: [BUS_W-1]=valid, [BUS_W-2:4]=payload, [3:0]=length code
CNT_W, A+2 (7), width of the internal capture counter

Ports:
clk  in  1  single clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
frame  in  1  link frame strobe, high for the duration of one transfer
msg  in  1  link serial data
bus_ack  in  1  downstream consumed bus_out; sampled on the rising edge
bus_out  out  BUS_W  rebuilt word; bit BUS_W-1 is the valid flag
frame_err  out  1  one-cycle pulse on a malformed or dropped frame

Behaviour:
- Reset (reset=0, async): bus_out=0, frame_err=0, shift register=0, counter=0, state=WAIT_LOW.
- Sampling: frame and msg are sampled only on rising clk edges. No negedge logic in this block.
- Link timing contract:
  - The first rising edge with frame=1 is a lead slot; that msg sample is discarded.
  - Each following rising edge with frame=1 captures one payload bit, MSB first.
  - The first rising edge with frame=0 ends the frame.
- State WAIT_LOW: entered after reset. Ignores the link until frame=0 is sampled, so a partial frame in progress at reset release is discarded. Then goes to IDLE.
- State IDLE: on frame=1, go to LEAD. Clear the counter and shift register. The msg sample on this edge is ignored.
- State SHIFT (entered from LEAD on the next edge with frame=1):
  - Each edge with frame=1: shift register <= {shift[30:0], msg}; counter += 1, saturating at 2**A+1 (33).
  - On an edge with frame=0: go to CHECK.
- LEAD with frame=0 on the next edge (zero payload bits) also goes to CHECK with counter=0.
- State CHECK (one cycle): counter N is legal iff N is in {1,2,4,8,16,32}.
  - Legal, and bus_out[BUS_W-1]=0: load bus_out = {1'b1, shift[31:0], code}, where code = log2(N) as 4 bits. Payload lands in bits [N+3:4]; bits above are 0. Go to HOLD.
  - Illegal (0, non-power-of-two, or >32): frame_err=1 for 1 cycle, bus_out unchanged, go to IDLE.
- State HOLD: bus_out is held stable.
  - On an edge with bus_ack=1: bus_out <= 0 and go to IDLE. This edge may also act as the IDLE frame=1 edge.
  - A frame starting while in HOLD is received normally. At its CHECK, bus_out still valid → frame_err pulse, new data dropped, old word kept (overrun).
- Latency: bus_out valid appears on the 2nd rising edge after the last payload capture (end-detect edge + CHECK edge).
- bus_ack while bus_out is invalid: ignored.
- frame_err is a registered single-cycle pulse; back-to-back errors produce separate pulses.
- Reset asserted mid-frame or during HOLD: immediate clear to reset values, then WAIT_LOW.
- Counter arithmetic: unsigned CNT_W bits; the power-of-two check is done on the saturated value.

Test Plan:
- 8-bit frame, payload 0xA5, code 3 → bus_out = {1, 24'h0, 8'hA5, 4'h3}; valid 2 edges after last bit; frame_err=0.
- 32-bit frame 0xDEADBEEF, code 5 → bus_out[35:4]=32'hDEADBEEF, [3:0]=5. Hold with bus_ack=0 for 10 cycles → word stable; bus_ack=1 → bus_out=0 next edge.
- 1-bit frame, msg=1, code 0 → bus_out = {1, 31'h0, 1'b1, 4'h0}.
- 3-bit frame, and separately a 40-bit frame → frame_err pulses exactly 1 cycle; bus_out stays 0.
- Overrun:
  - Stimulus: 4-bit frame 0x9 received, no ack; then a 2-bit frame 0x2.
  - Required: frame_err pulse; bus_out still {1, 28'h0, 4'h9, 4'h2}.
  - Then ack, then a 2-bit frame → bus_out = {1, 30'h0, 2'b10, 4'h1}.
- Reset pulsed at the 5th bit of a 16-bit frame:
  - Required: outputs 0 immediately; the rest of that frame is ignored (WAIT_LOW).
  - The next full 16-bit frame 0x1234 → bus_out[19:4]=16'h1234, code 4.
